// File: rtl/wc_job_scheduler.sv
// Word-count job scheduler: splits one host job into chunks and dispatches them
// round-robin to NUM_ENGINES engines. Optional job cycle counter under WC_SCHED_PERF_EN.
module wc_job_scheduler #(
  parameter int NUM_ENGINES    = 2,
  parameter int CHUNK_WORDS    = 128,
  parameter int BYTES_PER_WORD = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      kick,
  input  logic [31:0]               total_words,
  input  logic [63:0]               base_offset,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               chunks_issued,
  output logic [63:0]               cycle_count,
  output logic [NUM_ENGINES-1:0]    eng_kick,
  output logic [NUM_ENGINES*32-1:0] eng_num_of_words,
  output logic [NUM_ENGINES*64-1:0] eng_memory_offset,
  input  logic [NUM_ENGINES-1:0]    eng_busy,
  input  logic [NUM_ENGINES-1:0]    eng_axonerve_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [31:0]               remaining_q, remaining_d;
  logic [63:0]               offset_q, offset_d;
  logic [31:0]               chunks_q, chunks_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [NUM_ENGINES-1:0]    kick_q, kick_d;
  logic [NUM_ENGINES*32-1:0] words_q, words_d;
  logic [NUM_ENGINES*64-1:0] moff_q, moff_d;
  logic [NUM_ENGINES-1:0]    occ_q, occ_d;
  logic [NUM_ENGINES-1:0]    seen_q, seen_d;
  logic [3:0]                rr_q, rr_d;

  logic [NUM_ENGINES-1:0]    eligible;
  logic                      gnt_vld;
  logic [3:0]                gnt_idx;
  logic [3:0]                cand;
  logic [31:0]               chunk_len;

  assign eligible  = eng_axonerve_ready & ~occ_q & ~eng_busy;
  assign chunk_len = (remaining_q < 32'(CHUNK_WORDS)) ? remaining_q : 32'(CHUNK_WORDS);

  // Cyclic search for the first eligible engine starting at the round-robin pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      cand = rr_q + 4'(k);
      if (cand >= 4'(NUM_ENGINES)) cand = cand - 4'(NUM_ENGINES);
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (!gnt_vld && cand == 4'(i) && eligible[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = 4'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    offset_d    = offset_q;
    chunks_d    = chunks_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    kick_d      = '0;
    words_d     = words_q;
    moff_d      = moff_q;
    rr_d        = rr_q;
    occ_d       = occ_q;
    seen_d      = seen_q;

    // An engine is released only after its busy has been seen to rise and then fall.
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (occ_q[i] && eng_busy[i]) seen_d[i] = 1'b1;
      if (occ_q[i] && seen_q[i] && !eng_busy[i]) begin
        occ_d[i]  = 1'b0;
        seen_d[i] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (kick) begin
          remaining_d = total_words;
          offset_d    = base_offset;
          chunks_d    = '0;
          busy_d      = 1'b1;
          state_d     = (total_words == 32'd0) ? S_DRAIN : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (gnt_vld) begin
          for (int i = 0; i < NUM_ENGINES; i++) begin
            if (gnt_idx == 4'(i)) begin
              kick_d[i]          = 1'b1;
              words_d[32*i +: 32] = chunk_len;
              moff_d[64*i +: 64]  = offset_q;
              occ_d[i]           = 1'b1;
              seen_d[i]          = 1'b0;
            end
          end
          remaining_d = remaining_q - chunk_len;
          offset_d    = offset_q + 64'(chunk_len) * 64'(BYTES_PER_WORD);
          chunks_d    = chunks_q + 32'd1;
          rr_d        = (gnt_idx == 4'(NUM_ENGINES - 1)) ? 4'd0 : gnt_idx + 4'd1;
          if (remaining_q == chunk_len) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      offset_q    <= '0;
      chunks_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      kick_q      <= '0;
      words_q     <= '0;
      moff_q      <= '0;
      occ_q       <= '0;
      seen_q      <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      offset_q    <= offset_d;
      chunks_q    <= chunks_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      kick_q      <= kick_d;
      words_q     <= words_d;
      moff_q      <= moff_d;
      occ_q       <= occ_d;
      seen_q      <= seen_d;
      rr_q        <= rr_d;
    end
  end

`ifdef WC_SCHED_PERF_EN
  logic [63:0] cyc_q;

  // Counts cycles with busy high; freezes once busy drops at done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
    end else if (state_q == S_IDLE && kick) begin
      cyc_q <= '0;
    end else if (busy_q) begin
      cyc_q <= cyc_q + 64'd1;
    end
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = 64'h0;
`endif

  assign busy              = busy_q;
  assign done              = done_q;
  assign chunks_issued     = chunks_q;
  assign eng_kick          = kick_q;
  assign eng_num_of_words  = words_q;
  assign eng_memory_offset = moff_q;

endmodule
